// File: rtl/cpu_pkg.sv
// Shared CPU package: datapath widths, NOP encoding, fetch FSM states
// and the IF/ID pipeline bundle used by fetch and decode-side stages.
package cpu_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

    typedef enum logic {
        FS_BOOT,
        FS_RUN
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        pc:    '0,
        instr: NOP_INSTR,
        valid: 1'b0
    };

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/branch controls in, imem address/data,
// IF/ID register contents and performance counters out.
// slave = fetch stage, master = its environment.
interface if_stage_if
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic               pc_write;
    logic               if_id_write;
    logic               br_taken;
    logic [PC_W-1:0]    br_target;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [PC_W-1:0]    if_id_pc;
    logic [INSTR_W-1:0] if_id_instr;
    logic               if_id_valid;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        output pc_write, if_id_write, br_taken, br_target, imem_rdata,
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  pc_write, if_id_write, br_taken, br_target, imem_rdata,
        output imem_addr, if_id_pc, if_id_instr, if_id_valid,
        output stall_cnt, flush_cnt
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Ports: clk, reset (async, active-high),
// en (load d), flush (load bubble, wins over en), d, q.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= IF_ID_BUBBLE;
        end else if (flush) begin
            q <= IF_ID_BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, boot FSM, IF/ID
// register and stall/flush counters. Ports: clk, reset, bus (slave).
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
)(
    input  logic       clk,
    input  logic       reset,
    if_stage_if.slave  bus
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    fetch_state_t     state;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic   boot;
    logic   flush;
    if_id_t d;
    if_id_t q;

    assign boot = (state == FS_BOOT);
    // The boot cycle loads a bubble regardless of the controls.
    assign flush = boot | bus.br_taken;

    assign d = '{pc: pc, instr: bus.imem_rdata, valid: 1'b1};

    if_id_reg u_if_id (
        .clk   (clk),
        .reset (reset),
        .en    (bus.if_id_write),
        .flush (flush),
        .d     (d),
        .q     (q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FS_BOOT;
            pc        <= RESET_PC;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            unique case (state)
                FS_BOOT: begin
                    state <= FS_RUN;
                end
                FS_RUN: begin
                    if (bus.br_taken) begin
                        pc <= bus.br_target & ALIGN_MASK;
                    end else if (bus.pc_write) begin
                        pc <= pc + PC_W'(4);
                    end
                    if (!bus.pc_write && !bus.br_taken && stall_cnt != '1) begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                    if (bus.br_taken && flush_cnt != '1) begin
                        flush_cnt <= flush_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= FS_BOOT;
                end
            endcase
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.if_id_pc    = q.pc;
    assign bus.if_id_instr = q.instr;
    assign bus.if_id_valid = q.valid;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: table-driven fetch/stall/branch vectors plus
// hand-written counter-saturation and async-reset sequences.
module tb_if_stage;
    import cpu_pkg::*;

    localparam int CW = 4;
    localparam logic [PC_W-1:0] ONES = '1;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    if_stage_if #(.CNT_W(CW)) bus ();

    if_stage #(.RESET_PC('0), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] instr_at(logic [PC_W-1:0] a);
        return 32'hE000_0000 ^ a[31:0];
    endfunction

    always_comb bus.imem_rdata = instr_at(bus.imem_addr);

    typedef struct {
        logic            pw;
        logic            iw;
        logic            br;
        logic [PC_W-1:0] tgt;
        logic [PC_W-1:0] addr;
        logic [PC_W-1:0] ifpc;
        logic            valid;
        int              stall;
        int              flush;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(logic pw, logic iw, logic br, logic [PC_W-1:0] tgt);
        bus.pc_write    = pw;
        bus.if_id_write = iw;
        bus.br_taken    = br;
        bus.br_target   = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(string tag, logic [PC_W-1:0] ifpc, logic valid);
        chk({tag, ".valid"}, 64'(bus.if_id_valid), 64'(valid));
        chk({tag, ".ifpc"}, bus.if_id_pc, valid ? ifpc : '0);
        chk({tag, ".instr"}, 64'(bus.if_id_instr),
            64'(valid ? instr_at(ifpc) : NOP_INSTR));
    endtask

    function automatic vec_t mk(logic pw, logic iw, logic br,
                                logic [PC_W-1:0] tgt, logic [PC_W-1:0] addr,
                                logic [PC_W-1:0] ifpc, logic valid,
                                int stall, int flush);
        vec_t v;
        v.pw = pw; v.iw = iw; v.br = br; v.tgt = tgt;
        v.addr = addr; v.ifpc = ifpc; v.valid = valid;
        v.stall = stall; v.flush = flush;
        return v;
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        // BOOT ignores the branch in vector 0.
        vecs[0]  = mk(1, 1, 1, 'h80,  'h0,   'h0,   0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 'h0,   'h4,   'h0,   1, 0, 0);
        vecs[2]  = mk(1, 1, 0, 'h0,   'h8,   'h4,   1, 0, 0);
        vecs[3]  = mk(1, 1, 0, 'h0,   'hC,   'h8,   1, 0, 0);
        vecs[4]  = mk(1, 1, 0, 'h0,   'h10,  'hC,   1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 'h0,   'h10,  'hC,   1, 1, 0);
        vecs[6]  = mk(1, 1, 0, 'h0,   'h14,  'h10,  1, 1, 0);
        vecs[7]  = mk(1, 1, 0, 'h0,   'h18,  'h14,  1, 1, 0);
        vecs[8]  = mk(1, 1, 0, 'h0,   'h1C,  'h18,  1, 1, 0);
        vecs[9]  = mk(1, 1, 0, 'h0,   'h20,  'h1C,  1, 1, 0);
        vecs[10] = mk(1, 1, 1, 'h103, 'h100, 'h0,   0, 1, 1);
        vecs[11] = mk(1, 1, 0, 'h0,   'h104, 'h100, 1, 1, 1);
        vecs[12] = mk(0, 1, 0, 'h0,   'h104, 'h104, 1, 2, 1);
        vecs[13] = mk(0, 1, 0, 'h0,   'h104, 'h104, 1, 3, 1);
        vecs[14] = mk(1, 1, 0, 'h0,   'h108, 'h104, 1, 3, 1);
        vecs[15] = mk(0, 0, 1, 'h200, 'h200, 'h0,   0, 3, 2);
        vecs[16] = mk(1, 1, 0, 'h0,   'h204, 'h200, 1, 3, 2);
        vecs[17] = mk(1, 1, 1, ONES,  ONES - 'h3, 'h0, 0, 3, 3);
        vecs[18] = mk(1, 1, 0, 'h0,   'h0,   ONES - 'h3, 1, 3, 3);
        vecs[19] = mk(1, 1, 0, 'h0,   'h4,   'h0,   1, 3, 3);

        reset           = 1'b1;
        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
        bus.br_taken    = 1'b0;
        bus.br_target   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.addr", bus.imem_addr, '0);
        chk_ifid("rst", '0, 1'b0);
        chk("rst.stall", 64'(bus.stall_cnt), 0);
        chk("rst.flush", 64'(bus.flush_cnt), 0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            step(vecs[i].pw, vecs[i].iw, vecs[i].br, vecs[i].tgt);
            chk({tag, ".addr"}, bus.imem_addr, vecs[i].addr);
            chk_ifid(tag, vecs[i].ifpc, vecs[i].valid);
            chk({tag, ".stall"}, 64'(bus.stall_cnt), 64'(vecs[i].stall));
            chk({tag, ".flush"}, 64'(bus.flush_cnt), 64'(vecs[i].flush));
        end

        // Stall counter: 3 -> 15 after 12 stalls, then must not wrap.
        for (int i = 0; i < 13; i++) step(0, 0, 0, '0);
        chk("sat.stall", 64'(bus.stall_cnt), 15);
        chk("sat.addr", bus.imem_addr, 'h4);
        chk_ifid("sat", 'h0, 1'b1);

        // Flush counter: 3 -> 15 after 12 redirects, then must not wrap.
        for (int i = 0; i < 13; i++) step(1, 1, 1, 'h40);
        chk("satf.flush", 64'(bus.flush_cnt), 15);
        chk("satf.stall", 64'(bus.stall_cnt), 15);
        chk("satf.addr", bus.imem_addr, 'h40);
        chk_ifid("satf", '0, 1'b0);

        // Async reset in the middle of a stall cycle.
        step(1, 1, 0, '0);
        step(0, 0, 0, '0);
        #3;
        reset = 1'b1;
        #1;
        chk("arst.addr", bus.imem_addr, '0);
        chk_ifid("arst", '0, 1'b0);
        chk("arst.stall", 64'(bus.stall_cnt), 0);
        chk("arst.flush", 64'(bus.flush_cnt), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Back in BOOT: PC holds and the branch is ignored.
        step(1, 1, 1, 'h300);
        chk("boot2.addr", bus.imem_addr, '0);
        chk_ifid("boot2", '0, 1'b0);
        chk("boot2.flush", 64'(bus.flush_cnt), 0);
        step(1, 1, 0, '0);
        chk("run2.addr", bus.imem_addr, 'h4);
        chk_ifid("run2", 'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
